// File: rtl/pwr_seq_pkg.sv
// Shared definitions for the power-rail sequencer: FSM state encoding
// and default parameter values.
package pwr_seq_pkg;

  localparam int STATE_W          = 3;
  localparam int DEFAULT_DLY_W    = 16;
  localparam int DEFAULT_FILT_LEN = 4;

  typedef enum logic [STATE_W-1:0] {
    IDLE      = 3'd0,
    RAMP_UP   = 3'd1,
    ON        = 3'd2,
    RAMP_DOWN = 3'd3,
    FAULT     = 3'd4
  } seq_state_e;

endpackage

// File: rtl/pwr_rail_sequencer_alert_filter.sv
// Per-rail alert debouncer: two-flop synchroniser followed by a saturating
// run counter that qualifies FILT_LEN consecutive high samples.
module alert_filter
  import pwr_seq_pkg::*;
#(
  parameter int FILT_LEN = DEFAULT_FILT_LEN
) (
  input  logic clk_axi,
  input  logic rst_axi_n,
  input  logic alert_raw,
  output logic filt
);

  localparam int CW = $clog2(FILT_LEN + 1);

  logic          sync1_q;
  logic          sync2_q;
  logic [CW-1:0] runCnt_q;

  // A single low sample restarts the run, so only an unbroken run qualifies.
  always_ff @(posedge clk_axi or negedge rst_axi_n) begin
    if (!rst_axi_n) begin
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      runCnt_q <= '0;
    end else begin
      sync1_q <= alert_raw;
      sync2_q <= sync1_q;
      if (!sync2_q) begin
        runCnt_q <= '0;
      end else if (runCnt_q != CW'(FILT_LEN)) begin
        runCnt_q <= runCnt_q + CW'(1);
      end
    end
  end

  assign filt = (runCnt_q == CW'(FILT_LEN));

endmodule

// File: rtl/pwr_rail_sequencer.sv
// Power-rail sequencer: ramps rail enables up in index order and down in
// reverse, with debounced per-rail alerts that latch a fault and drop all rails.
module pwr_rail_sequencer
  import pwr_seq_pkg::*;
#(
  parameter int N_CH     = 8,
  parameter int DLY_W    = DEFAULT_DLY_W,
  parameter int FILT_LEN = DEFAULT_FILT_LEN
) (
  input  logic               clk_axi,
  input  logic               rst_axi_n,
  input  logic               master_en,
  input  logic [N_CH-1:0]    ch_mask,
  input  logic [N_CH-1:0]    alert_mask,
  input  logic [DLY_W-1:0]   seq_delay,
  input  logic               fault_clr,
  input  logic [N_CH-1:0]    alert_raw,
  output logic [N_CH-1:0]    en_out,
  output logic [N_CH-1:0]    fault_latched,
  output logic [STATE_W-1:0] state_o,
  output logic               busy
);

  seq_state_e       state_q;
  logic [N_CH-1:0]  enOut_q;
  logic [N_CH-1:0]  fault_q;
  logic [N_CH-1:0]  mask_q;
  logic [DLY_W-1:0] cnt_q;

  logic [N_CH-1:0]  filtVec;
  logic [N_CH-1:0]  eligible;
  logic [N_CH-1:0]  upPick;
  logic [N_CH-1:0]  downPick;
  logic [N_CH-1:0]  tripVec;
  logic             tripActive;

  for (genvar g = 0; g < N_CH; g++) begin : gen_filt
    alert_filter #(
      .FILT_LEN (FILT_LEN)
    ) u_alert_filter (
      .clk_axi   (clk_axi),
      .rst_axi_n (rst_axi_n),
      .alert_raw (alert_raw[g]),
      .filt      (filtVec[g])
    );
  end

  assign eligible = mask_q & ~enOut_q;
  assign upPick   = eligible & (~eligible + N_CH'(1));
  assign tripVec  = filtVec & alert_mask & enOut_q;
  assign tripActive = (state_q != IDLE) && (state_q != FAULT) && (|tripVec);

  // Highest enabled rail is the next one to drop during ramp-down.
  always_comb begin
    downPick = '0;
    for (int i = 0; i < N_CH; i++) begin
      if (enOut_q[i]) begin
        downPick    = '0;
        downPick[i] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_axi or negedge rst_axi_n) begin
    if (!rst_axi_n) begin
      state_q <= IDLE;
      enOut_q <= '0;
      fault_q <= '0;
      mask_q  <= '0;
      cnt_q   <= '0;
    end else if (tripActive) begin
      enOut_q <= '0;
      fault_q <= fault_q | tripVec;
      state_q <= FAULT;
    end else begin
      case (state_q)
        IDLE: begin
          if (master_en) begin
            mask_q  <= ch_mask;
            cnt_q   <= '0;
            state_q <= RAMP_UP;
          end
        end
        RAMP_UP: begin
          if (!master_en) begin
            cnt_q   <= '0;
            state_q <= RAMP_DOWN;
          end else if (eligible == '0) begin
            state_q <= ON;
          end else if (cnt_q == '0) begin
            enOut_q <= enOut_q | upPick;
            cnt_q   <= seq_delay;
          end else begin
            cnt_q <= cnt_q - DLY_W'(1);
          end
        end
        ON: begin
          if (!master_en) begin
            cnt_q   <= '0;
            state_q <= RAMP_DOWN;
          end
        end
        RAMP_DOWN: begin
          // Re-enabling resumes from the rails still up, using the original mask.
          if (master_en) begin
            cnt_q   <= '0;
            state_q <= RAMP_UP;
          end else if (enOut_q == '0) begin
            state_q <= IDLE;
          end else if (cnt_q == '0) begin
            enOut_q <= enOut_q & ~downPick;
            cnt_q   <= seq_delay;
          end else begin
            cnt_q <= cnt_q - DLY_W'(1);
          end
        end
        FAULT: begin
          if (fault_clr && !master_en) begin
            fault_q <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign en_out        = enOut_q;
  assign fault_latched = fault_q;
  assign state_o       = state_q;
  assign busy          = (state_q == RAMP_UP) || (state_q == RAMP_DOWN);

endmodule

// File: tb/tb_pwr_rail_sequencer.sv
// Self-checking bench for pwr_rail_sequencer: a cycle-indexed vector table
// feeding a scoreboard, plus hand-written multi-cycle corner cases.
module tb_pwr_rail_sequencer;
  import pwr_seq_pkg::*;

  localparam int N_CH     = 8;
  localparam int DLY_W    = 16;
  localparam int FILT_LEN = 4;
  localparam int LAST_CYC = 180;

  logic              clk_axi = 1'b0;
  logic              rst_axi_n = 1'b0;
  logic              master_en = 1'b0;
  logic [N_CH-1:0]   ch_mask = '0;
  logic [N_CH-1:0]   alert_mask = '0;
  logic [DLY_W-1:0]  seq_delay = '0;
  logic              fault_clr = 1'b0;
  logic [N_CH-1:0]   alert_raw = '0;
  logic [N_CH-1:0]   en_out;
  logic [N_CH-1:0]   fault_latched;
  logic [STATE_W-1:0] state_o;
  logic              busy;

  pwr_rail_sequencer #(
    .N_CH     (N_CH),
    .DLY_W    (DLY_W),
    .FILT_LEN (FILT_LEN)
  ) dut (
    .clk_axi       (clk_axi),
    .rst_axi_n     (rst_axi_n),
    .master_en     (master_en),
    .ch_mask       (ch_mask),
    .alert_mask    (alert_mask),
    .seq_delay     (seq_delay),
    .fault_clr     (fault_clr),
    .alert_raw     (alert_raw),
    .en_out        (en_out),
    .fault_latched (fault_latched),
    .state_o       (state_o),
    .busy          (busy)
  );

  always #5 clk_axi = ~clk_axi;

  typedef struct {
    int         cyc;
    logic       me;
    logic [7:0] cmask;
    logic [7:0] amask;
    logic [7:0] alert;
    logic       fclr;
    logic [7:0] en;
    logic [7:0] flt;
    logic [2:0] st;
  } vec_t;

  typedef struct {
    string      name;
    logic [7:0] en;
    logic [7:0] flt;
    logic [2:0] st;
    logic       busy;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   compared = 0;
  int   mismatched = 0;

  function automatic logic busyOf(input logic [2:0] st);
    return (st == RAMP_UP) || (st == RAMP_DOWN);
  endfunction

  task automatic compareVal(input string n, input logic [7:0] act, input logic [7:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s actual=%0h expected=%0h", n, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic me, input logic [7:0] cm, input logic [7:0] am,
                               input logic [7:0] al, input logic fc);
    master_en  = me;
    ch_mask    = cm;
    alert_mask = am;
    alert_raw  = al;
    fault_clr  = fc;
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL scoreboard_empty actual=0 expected=1 entry");
      return;
    end
    e = sb.pop_front();
    compareVal({e.name, "/en_out"}, en_out, e.en);
    compareVal({e.name, "/fault_latched"}, fault_latched, e.flt);
    compareVal({e.name, "/state_o"}, 8'(state_o), 8'(e.st));
    compareVal({e.name, "/busy"}, 8'(busy), 8'(e.busy));
  endtask

  task automatic stepExpect(input string n, input logic [7:0] en, input logic [7:0] flt,
                            input logic [2:0] st);
    sb.push_back('{n, en, flt, st, busyOf(st)});
    @(posedge clk_axi);
    #1;
    checkOutput();
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int   idx;
    vec_t cur;

    // Ramp-up with mask 0x2D, delay 3
    tbl.push_back('{  0, 1'b1, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, RAMP_UP});
    tbl.push_back('{  1, 1'b1, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h01, 8'h00, RAMP_UP});
    tbl.push_back('{  5, 1'b1, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h05, 8'h00, RAMP_UP});
    tbl.push_back('{  9, 1'b1, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h0D, 8'h00, RAMP_UP});
    tbl.push_back('{ 13, 1'b1, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h2D, 8'h00, RAMP_UP});
    tbl.push_back('{ 14, 1'b1, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h2D, 8'h00, ON});
    // Ramp-down in reverse order 5,3,2,0
    tbl.push_back('{ 20, 1'b0, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h2D, 8'h00, RAMP_DOWN});
    tbl.push_back('{ 21, 1'b0, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h0D, 8'h00, RAMP_DOWN});
    tbl.push_back('{ 25, 1'b0, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h05, 8'h00, RAMP_DOWN});
    tbl.push_back('{ 29, 1'b0, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h01, 8'h00, RAMP_DOWN});
    tbl.push_back('{ 33, 1'b0, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, RAMP_DOWN});
    tbl.push_back('{ 34, 1'b0, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, IDLE});
    // Back up, then alert pulses on channel 2
    tbl.push_back('{ 40, 1'b1, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, RAMP_UP});
    tbl.push_back('{ 41, 1'b1, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h01, 8'h00, RAMP_UP});
    tbl.push_back('{ 45, 1'b1, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h05, 8'h00, RAMP_UP});
    tbl.push_back('{ 49, 1'b1, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h0D, 8'h00, RAMP_UP});
    tbl.push_back('{ 53, 1'b1, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h2D, 8'h00, RAMP_UP});
    tbl.push_back('{ 54, 1'b1, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h2D, 8'h00, ON});
    tbl.push_back('{ 60, 1'b1, 8'h2D, 8'hFF, 8'h04, 1'b0, 8'h2D, 8'h00, ON});
    tbl.push_back('{ 63, 1'b1, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h2D, 8'h00, ON});
    tbl.push_back('{ 70, 1'b1, 8'h2D, 8'hFF, 8'h04, 1'b0, 8'h2D, 8'h00, ON});
    tbl.push_back('{ 76, 1'b1, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h04, FAULT});
    // Fault clear ignored while master_en=1, honoured once it drops
    tbl.push_back('{ 80, 1'b1, 8'h2D, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h04, FAULT});
    tbl.push_back('{ 81, 1'b1, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h04, FAULT});
    tbl.push_back('{ 85, 1'b0, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h04, FAULT});
    tbl.push_back('{ 87, 1'b0, 8'h2D, 8'hFF, 8'h00, 1'b1, 8'h00, 8'h00, IDLE});
    tbl.push_back('{ 88, 1'b0, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, IDLE});
    // Mask 0x2F with alert_mask[1]=0; alerts on masked ch1 and disabled ch6
    tbl.push_back('{100, 1'b1, 8'h2F, 8'hFD, 8'h00, 1'b0, 8'h00, 8'h00, RAMP_UP});
    tbl.push_back('{101, 1'b1, 8'h2F, 8'hFD, 8'h00, 1'b0, 8'h01, 8'h00, RAMP_UP});
    tbl.push_back('{105, 1'b1, 8'h2F, 8'hFD, 8'h00, 1'b0, 8'h03, 8'h00, RAMP_UP});
    tbl.push_back('{109, 1'b1, 8'h2F, 8'hFD, 8'h00, 1'b0, 8'h07, 8'h00, RAMP_UP});
    tbl.push_back('{113, 1'b1, 8'h2F, 8'hFD, 8'h00, 1'b0, 8'h0F, 8'h00, RAMP_UP});
    tbl.push_back('{117, 1'b1, 8'h2F, 8'hFD, 8'h00, 1'b0, 8'h2F, 8'h00, RAMP_UP});
    tbl.push_back('{118, 1'b1, 8'h2F, 8'hFD, 8'h00, 1'b0, 8'h2F, 8'h00, ON});
    tbl.push_back('{120, 1'b1, 8'hFF, 8'hFD, 8'h42, 1'b0, 8'h2F, 8'h00, ON});
    tbl.push_back('{130, 1'b1, 8'hFF, 8'hFD, 8'h00, 1'b0, 8'h2F, 8'h00, ON});
    tbl.push_back('{140, 1'b0, 8'hFF, 8'hFD, 8'h00, 1'b0, 8'h2F, 8'h00, RAMP_DOWN});
    tbl.push_back('{141, 1'b0, 8'hFF, 8'hFD, 8'h00, 1'b0, 8'h0F, 8'h00, RAMP_DOWN});
    tbl.push_back('{145, 1'b0, 8'hFF, 8'hFD, 8'h00, 1'b0, 8'h07, 8'h00, RAMP_DOWN});
    tbl.push_back('{149, 1'b0, 8'hFF, 8'hFD, 8'h00, 1'b0, 8'h03, 8'h00, RAMP_DOWN});
    tbl.push_back('{153, 1'b0, 8'hFF, 8'hFD, 8'h00, 1'b0, 8'h01, 8'h00, RAMP_DOWN});
    tbl.push_back('{157, 1'b0, 8'hFF, 8'hFD, 8'h00, 1'b0, 8'h00, 8'h00, RAMP_DOWN});
    tbl.push_back('{158, 1'b0, 8'hFF, 8'hFD, 8'h00, 1'b0, 8'h00, 8'h00, IDLE});
    // Reversal after two rails: bit 2 then bit 0 clear
    tbl.push_back('{165, 1'b1, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, RAMP_UP});
    tbl.push_back('{166, 1'b1, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h01, 8'h00, RAMP_UP});
    tbl.push_back('{170, 1'b1, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h05, 8'h00, RAMP_UP});
    tbl.push_back('{171, 1'b0, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h05, 8'h00, RAMP_DOWN});
    tbl.push_back('{172, 1'b0, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h01, 8'h00, RAMP_DOWN});
    tbl.push_back('{176, 1'b0, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, RAMP_DOWN});
    tbl.push_back('{177, 1'b0, 8'h2D, 8'hFF, 8'h00, 1'b0, 8'h00, 8'h00, IDLE});

    $display("[TB] reset phase");
    seq_delay = 16'd3;
    applyStimulus(1'b0, 8'h2D, 8'hFF, 8'h00, 1'b0);
    repeat (3) @(posedge clk_axi);
    #1;
    compareVal("reset/en_out", en_out, 8'h00);
    compareVal("reset/fault_latched", fault_latched, 8'h00);
    compareVal("reset/state_o", 8'(state_o), 8'(IDLE));
    compareVal("reset/busy", 8'(busy), 8'h00);
    @(negedge clk_axi);
    rst_axi_n = 1'b1;
    @(posedge clk_axi);
    #1;

    $display("[TB] table phase");
    idx = 0;
    cur = tbl[0];
    for (int c = 0; c <= LAST_CYC; c++) begin
      if (idx < tbl.size() && tbl[idx].cyc == c) begin
        cur = tbl[idx];
        applyStimulus(cur.me, cur.cmask, cur.amask, cur.alert, cur.fclr);
        idx++;
      end
      stepExpect($sformatf("tbl_c%0d", c), cur.en, cur.flt, cur.st);
    end

    $display("[TB] seq_delay=0 ramp");
    seq_delay = 16'd0;
    applyStimulus(1'b1, 8'h81, 8'hFF, 8'h00, 1'b0);
    stepExpect("d0_up0", 8'h00, 8'h00, RAMP_UP);
    stepExpect("d0_up1", 8'h01, 8'h00, RAMP_UP);
    stepExpect("d0_up2", 8'h81, 8'h00, RAMP_UP);
    stepExpect("d0_on",  8'h81, 8'h00, ON);
    applyStimulus(1'b0, 8'h81, 8'hFF, 8'h00, 1'b0);
    stepExpect("d0_dn0", 8'h81, 8'h00, RAMP_DOWN);
    stepExpect("d0_dn1", 8'h01, 8'h00, RAMP_DOWN);
    stepExpect("d0_dn2", 8'h00, 8'h00, RAMP_DOWN);
    stepExpect("d0_idle", 8'h00, 8'h00, IDLE);

    $display("[TB] empty mask");
    applyStimulus(1'b1, 8'h00, 8'hFF, 8'h00, 1'b0);
    stepExpect("m0_up", 8'h00, 8'h00, RAMP_UP);
    stepExpect("m0_on", 8'h00, 8'h00, ON);
    applyStimulus(1'b0, 8'h00, 8'hFF, 8'h00, 1'b0);
    stepExpect("m0_dn", 8'h00, 8'h00, RAMP_DOWN);
    stepExpect("m0_idle", 8'h00, 8'h00, IDLE);

    $display("[TB] resume from ramp-down");
    applyStimulus(1'b1, 8'h07, 8'hFF, 8'h00, 1'b0);
    stepExpect("rs_up0", 8'h00, 8'h00, RAMP_UP);
    stepExpect("rs_up1", 8'h01, 8'h00, RAMP_UP);
    stepExpect("rs_up2", 8'h03, 8'h00, RAMP_UP);
    stepExpect("rs_up3", 8'h07, 8'h00, RAMP_UP);
    stepExpect("rs_on",  8'h07, 8'h00, ON);
    applyStimulus(1'b0, 8'h00, 8'hFF, 8'h00, 1'b0);
    stepExpect("rs_dn0", 8'h07, 8'h00, RAMP_DOWN);
    stepExpect("rs_dn1", 8'h03, 8'h00, RAMP_DOWN);
    applyStimulus(1'b1, 8'h00, 8'hFF, 8'h00, 1'b0);
    stepExpect("rs_re0", 8'h03, 8'h00, RAMP_UP);
    stepExpect("rs_re1", 8'h07, 8'h00, RAMP_UP);
    stepExpect("rs_re2", 8'h07, 8'h00, ON);
    applyStimulus(1'b0, 8'h00, 8'hFF, 8'h00, 1'b0);
    stepExpect("rs_fd0", 8'h07, 8'h00, RAMP_DOWN);
    stepExpect("rs_fd1", 8'h03, 8'h00, RAMP_DOWN);
    stepExpect("rs_fd2", 8'h01, 8'h00, RAMP_DOWN);
    stepExpect("rs_fd3", 8'h00, 8'h00, RAMP_DOWN);
    stepExpect("rs_idle", 8'h00, 8'h00, IDLE);

    $display("[TB] async reset mid-ramp");
    seq_delay = 16'd3;
    applyStimulus(1'b1, 8'h2D, 8'hFF, 8'h00, 1'b0);
    stepExpect("ar_up0", 8'h00, 8'h00, RAMP_UP);
    stepExpect("ar_up1", 8'h01, 8'h00, RAMP_UP);
    stepExpect("ar_up2", 8'h01, 8'h00, RAMP_UP);
    #2;
    rst_axi_n = 1'b0;
    #1;
    compareVal("ar_async/en_out", en_out, 8'h00);
    compareVal("ar_async/state_o", 8'(state_o), 8'(IDLE));
    compareVal("ar_async/busy", 8'(busy), 8'h00);
    applyStimulus(1'b0, 8'h2D, 8'hFF, 8'h00, 1'b0);
    @(negedge clk_axi);
    rst_axi_n = 1'b1;
    @(posedge clk_axi);
    #1;
    stepExpect("ar_idle", 8'h00, 8'h00, IDLE);

    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("[TB] FAIL scoreboard_drain actual=%0d expected=0", sb.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/pwr_rail_sequencer.md
Name: pwr_rail_sequencer

Overview:
- Parametrised successor to the direct register-to-pin rail enables: drives N_CH power-rail enable pins (EN_3V3, EN_2V5, VP12_EN0..5 class) from AXI control-register bits.
- Turns rails on in a timed sequence and off in reverse order.
- Debounces per-rail alert inputs and latches faults; a fault forces every rail off.
- Sits between the AXI register bank (reg_rw_in / reg_ro_out) and the board IO in the top level.

Parameters:
- N_CH, 8, number of rail channels (1..16).
- DLY_W, 16, width of the inter-step delay count.
- FILT_LEN, 4, consecutive synchronised high samples needed to qualify an alert (1..15).

Ports:
- clk_axi  in  1  single clock for all logic.
- rst_axi_n  in  1  asynchronous active-low reset.
- master_en  in  1  register bit; 1 = rails up, 0 = rails down.
- ch_mask  in  N_CH  register; rails taking part in the sequence.
- alert_mask  in  N_CH  register; rails whose alert may trip a fault.
- seq_delay  in  DLY_W  register; step spacing is seq_delay+1 cycles.
- fault_clr  in  1  one-cycle pulse from register write.
- alert_raw  in  N_CH  asynchronous board alert inputs, active high.
- en_out  out  N_CH  registered rail enables.
- fault_latched  out  N_CH  sticky per-rail fault flags.
- state_o  out  3  FSM state, for reg_ro_out.
- busy  out  1  high in RAMP_UP or RAMP_DOWN.

Behaviour:
- Reset (async, rst_axi_n=0): en_out=0, fault_latched=0, state=IDLE, busy=0, delay counter=0, mask_q=0, filter state=0.
- States: IDLE=0, RAMP_UP=1, ON=2, RAMP_DOWN=3, FAULT=4.
- IDLE
  - On the edge where master_en=1: latch mask_q<=ch_mask, cnt<=0, go to RAMP_UP.
- RAMP_UP
  - When cnt==0, set en_out for the lowest-index bit with mask_q=1 and en_out=0, and reload cnt<=seq_delay. Otherwise cnt decrements.
  - First rail asserts one cycle after entry; later rails assert every seq_delay+1 cycles.
  - When no eligible bit remains, go to ON in the cycle after the last enable.
  - mask_q=0 means RAMP_UP exits to ON after one cycle with en_out unchanged.
- ON
  - en_out is held.
  - ch_mask changes are ignored until the next IDLE->RAMP_UP transition.
- master_en=0 while in RAMP_UP or ON: go to RAMP_DOWN with cnt<=0.
- RAMP_DOWN
  - When cnt==0, clear the highest-index set en_out bit and reload cnt<=seq_delay.
  - When en_out==0, go to IDLE.
  - master_en=1 while in RAMP_DOWN: go to RAMP_UP with cnt<=0 and resume from the current en_out. mask_q is not re-latched.
- Alert path, per channel (sub-module):
  - 2-flop synchroniser, then a saturating run counter.
  - filt=1 once FILT_LEN consecutive synchronised 1s are seen; filt clears on the first synchronised 0.
  - Latency from alert_raw rising to filt is 2+FILT_LEN cycles.
- Fault trip
  - Condition: in any state except IDLE and FAULT, filt[i] & alert_mask[i] & en_out[i].
  - On the next edge: en_out<=0 (all rails), fault_latched[i]<=1 for every channel meeting the condition that cycle, state<=FAULT.
  - Fault takes priority over master_en and over the step counter in the same cycle.
- FAULT
  - en_out stays 0 and fault_latched is held.
  - Leave only on an edge with fault_clr=1 AND master_en=0: fault_latched<=0, go to IDLE.
  - fault_clr with master_en=1 is ignored; so is fault_clr outside FAULT.
- Arithmetic: cnt is an unsigned DLY_W-bit counter with no wrap; it decrements only while non-zero. seq_delay=0 gives one rail per cycle.
- seq_delay is sampled on every reload, so a change mid-ramp affects the next step.

Decomposition:
- Shared package pwr_seq_pkg: state encoding constants (IDLE..FAULT), state width 3, and default FILT_LEN and DLY_W.
- One sub-module, alert_filter: parameter FILT_LEN; ports clk_axi, rst_axi_n, alert_raw, filt. Instantiated N_CH times via generate.
- Main FSM, counter and priority encoders live in pwr_rail_sequencer.

Test Plan:
- Ramp-up: N_CH=8, ch_mask=0x2D, seq_delay=3, master_en 0->1 at t0.
  - Required: en_out bits 0,2,3,5 assert at t0+1, +5, +9, +13.
  - state=ON at t0+14; busy high only during RAMP_UP.
- Ramp-down: from the end of the ramp-up test, master_en 1->0 at t1.
  - Required: bits clear in order 5,3,2,0 at t1+1, +5, +9, +13.
  - state=IDLE at t1+14.
- Alert debounce: FILT_LEN=4, rails ON, alert_mask=0xFF.
  - 3-cycle pulse on alert_raw[2]: no fault.
  - 6-cycle pulse: en_out=0 at 7 cycles after the rising edge (2 sync + 4 filter + 1 trip); fault_latched=0x04; state=FAULT.
- Masked or disabled rail: alert on channel 1 with alert_mask[1]=0 -> no fault. Alert on channel 6 with en_out[6]=0 -> no fault.
- Fault clear: in FAULT, fault_clr with master_en=1 -> still FAULT. master_en=0 then fault_clr -> fault_latched=0 and IDLE next cycle.
- Reversal and reset:
  - master_en dropped after 2 rails in RAMP_UP -> RAMP_DOWN clears bit order 2 then 0.
  - rst_axi_n asserted mid-ramp -> en_out=0 immediately (asynchronous), state=IDLE.
